lottery_drawer: RTL and testbench



---
 rtl/lottery_pkg.sv | 13 +
 rtl/lottery_drawer_if.sv | 33 +++
 rtl/lottery_drawer.sv | 107 ++++++++++
 tb/tb_lottery_drawer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lottery_pkg.sv
// lottery_pkg: shared types and constants for the lottery drawer.
// Holds the draw FSM state type and the default board size.
package lottery_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DONE
  } draw_state_t;

  localparam int BOARD_CELLS = 196;

endpackage

// File: rtl/lottery_drawer_if.sv
// lottery_drawer_if: request/result bundle between a drawer and its user.
// master = requester/counter side, slave = the drawer.
interface lottery_drawer_if #(
  parameter int BIT_WIDTH = 10,
  parameter int RANGE     = 196
);
  localparam int IDX_W = $clog2(RANGE);

  logic [BIT_WIDTH-1:0] number_i;
  logic                 draw_req_i;
  logic                 busy_o;
  logic                 done_o;
  logic [IDX_W-1:0]     result_o;
  logic                 fallback_o;

  modport master (
    output number_i,
    output draw_req_i,
    input  busy_o,
    input  done_o,
    input  result_o,
    input  fallback_o
  );

  modport slave (
    input  number_i,
    input  draw_req_i,
    output busy_o,
    output done_o,
    output result_o,
    output fallback_o
  );
endinterface

// File: rtl/lottery_drawer.sv
// lottery_drawer: bounded rejection sampler giving an index in [0, RANGE).
// Optional macro LOTTERY_NO_REPEAT_EN also rejects a repeat of the last result.
module lottery_drawer
  import lottery_pkg::*;
#(
  parameter int BIT_WIDTH = 10,
  parameter int RANGE     = BOARD_CELLS,
  parameter int MAX_TRIES = 4
) (
  input logic clock,
  input logic reset,
  lottery_drawer_if.slave bus
);
  localparam int IDX_W = $clog2(RANGE);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [IDX_W:0] RANGE_V = RANGE[IDX_W:0];
  localparam logic [IDX_W-1:0] TOP_V = RANGE_V[IDX_W-1:0] - 1'b1;
  localparam logic [TRY_W-1:0] LAST_T = TRY_W'(MAX_TRIES - 1);

  draw_state_t      state;
  logic [TRY_W-1:0] tries;
  logic [IDX_W-1:0] result;
  logic             fb;

  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   cand_ext;
  logic [IDX_W:0]   diff;
  logic             in_range;
  logic             is_rep;
  logic             accept;
  logic [IDX_W-1:0] fb_val;

`ifdef LOTTERY_NO_REPEAT_EN
  logic             last_valid;
  logic [IDX_W-1:0] last_result;
`endif

  // Candidate decode: range/repeat check and fallback value
  always_comb begin
    cand     = bus.number_i[IDX_W-1:0];
    cand_ext = {1'b0, cand};
    diff     = cand_ext - RANGE_V;
    in_range = cand_ext < RANGE_V;
`ifdef LOTTERY_NO_REPEAT_EN
    is_rep   = last_valid && (cand == last_result);
`else
    is_rep   = 1'b0;
`endif
    accept   = in_range && !is_rep;
    if (!in_range)
      fb_val = diff[IDX_W-1:0];
    else if (cand == TOP_V)
      fb_val = '0;
    else
      fb_val = cand + 1'b1;
  end

  // Draw FSM and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      tries  <= '0;
      result <= '0;
      fb     <= 1'b0;
`ifdef LOTTERY_NO_REPEAT_EN
      last_valid  <= 1'b0;
      last_result <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.draw_req_i) begin
            tries <= '0;
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (accept) begin
            result <= cand;
            fb     <= 1'b0;
            state  <= DONE;
          end else if (tries == LAST_T) begin
            result <= fb_val;
            fb     <= 1'b1;
            state  <= DONE;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        DONE: begin
`ifdef LOTTERY_NO_REPEAT_EN
          last_valid  <= 1'b1;
          last_result <= result;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o     = (state != IDLE);
  assign bus.done_o     = (state == DONE);
  assign bus.result_o   = result;
  assign bus.fallback_o = fb;

endmodule

// File: tb/tb_lottery_drawer.sv
// tb_lottery_drawer: directed and random draws against a sampling model.
// Model follows the draw rules on plain integers, sample by sample.
module tb_lottery_drawer;
  localparam int BW    = 10;
  localparam int RNG   = 196;
  localparam int TRIES = 4;
  localparam int IW    = $clog2(RNG);
`ifdef LOTTERY_NO_REPEAT_EN
  localparam bit NR = 1'b1;
`else
  localparam bit NR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  lottery_drawer_if #(.BIT_WIDTH(BW), .RANGE(RNG)) bus ();

  lottery_drawer #(
    .BIT_WIDTH(BW),
    .RANGE(RNG),
    .MAX_TRIES(TRIES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errs    = 0;
  bit has_last = 1'b0;
  int last_res = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int n[4], output int r,
                                output bit fb, output int k);
    int c;
    bit rep;
    r = 0; fb = 1'b0; k = TRIES - 1;
    for (int i = 0; i < TRIES; i++) begin
      c   = n[i] % (1 << IW);
      rep = NR && has_last && (c == last_res);
      if (c < RNG && !rep) begin
        r = c; fb = 1'b0; k = i;
        return;
      end
      if (i == TRIES - 1) begin
        fb = 1'b1; k = i;
        r  = (c >= RNG) ? c - RNG : (c + 1) % RNG;
      end
    end
  endfunction

  task automatic draw(input string tag, input int n[4], input bit req_hold);
    int  er, ek, cyc;
    bit  efb, seen;
    model(n, er, efb, ek);
    bus.draw_req_i = 1'b1;
    bus.number_i   = '0;
    @(posedge clock);
    @(negedge clock);
    bus.draw_req_i = req_hold;
    chk({tag, ".busy"}, int'(bus.busy_o), 1);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 12 && !seen) begin
      bus.number_i = BW'(n[cyc < 4 ? cyc : 3]);
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (bus.done_o) seen = 1'b1;
      else if (!bus.busy_o) cyc = 99;
    end
    bus.draw_req_i = 1'b0;
    chk({tag, ".lat"}, cyc, ek + 1);
    chk({tag, ".res"}, int'(bus.result_o), er);
    chk({tag, ".fb"}, int'(bus.fallback_o), int'(efb));
    @(posedge clock);
    @(negedge clock);
    chk({tag, ".done1"}, int'(bus.done_o), 0);
    chk({tag, ".idle"}, int'(bus.busy_o), 0);
    chk({tag, ".hold"}, int'(bus.result_o), er);
    if (seen) begin
      has_last = 1'b1;
      last_res = er;
    end
  endtask

  initial begin
    int n[4];
    bus.draw_req_i = 1'b0;
    bus.number_i   = '0;
    repeat (2) @(negedge clock);
    chk("rst.busy", int'(bus.busy_o), 0);
    chk("rst.done", int'(bus.done_o), 0);
    chk("rst.res", int'(bus.result_o), 0);
    chk("rst.fb", int'(bus.fallback_o), 0);
    reset = 1'b0;
    @(negedge clock);

    n = '{37, 37, 37, 37};
    draw("t1", n, 1'b0);
    chk("t1.val", int'(bus.result_o), 37);

    n = '{200, 201, 50, 50};
    draw("t2", n, 1'b0);

    n = '{250, 250, 250, 250};
    draw("t3", n, 1'b0);
    chk("t3.val", int'(bus.result_o), 54);

    n = '{'h3C5, 'h3C5, 'h3C5, 'h3C5};
    draw("t3b", n, 1'b0);

    n = '{195, 1, 2, 3};
    draw("t4a", n, 1'b0);
    n = '{196, 100, 3, 4};
    draw("t4b", n, 1'b0);

    n = '{300, 400, 12, 13};
    draw("t5", n, 1'b1);

    bus.draw_req_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.draw_req_i = 1'b0;
    bus.number_i   = BW'(250);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst.mid.busy", int'(bus.busy_o), 0);
    chk("rst.mid.done", int'(bus.done_o), 0);
    chk("rst.mid.res", int'(bus.result_o), 0);
    has_last = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    n = '{37, 37, 37, 37};
    draw("t6a", n, 1'b0);
    n = '{37, 38, 38, 38};
    draw("t6b", n, 1'b0);
    chk("t6.val", int'(bus.result_o), NR ? 38 : 37);

    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 4; j++)
        n[j] = (i % 2) ? $urandom_range(0, 1023) : $urandom_range(180, 255);
      draw("rnd", n, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
